fsub_single_seq: RTL and testbench

FSUB_SINGLE_SEQ -- requirements
Module: fsub_single_seq

---
 rtl/fsub_single_seq.sv | 181 ++++++++++++++++++
 tb/tb_fsub_single_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fsub_single_seq.sv
// IEEE-754 single-precision subtractor c = a - b, one FSM state per stage (unpack/align/add/norm/round).
// done pulses in the 5th cycle after acceptance; start is ignored while busy, so there is no queueing.
module fsub_single_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] c
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state, state_nxt;

    logic [31:0] op_a, op_b;
    logic        sx, sy;
    logic [7:0]  ex, ey;
    logic [23:0] mx, my;
    logic        spec_vld;
    logic [31:0] spec_val;
    logic [26:0] xe, ye;
    logic [27:0] sum;
    logic [26:0] nm;
    logic [9:0]  ne;
    logic        nz, nz_sign;
    logic [31:0] c_hold, res;

    // Unpack: b's sign is inverted so the rest of the datapath is a plain add.
    logic [7:0]  ea, eb;
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [30:0] mag_a, mag_b;
    logic [23:0] ma, mb;
    logic        u_spec_vld;
    logic [31:0] u_spec_val;
    always_comb begin
        ea    = op_a[30:23];
        eb    = op_b[30:23];
        sa    = op_a[31];
        sb    = ~op_b[31];
        a_nan = (ea == 8'hff) && (op_a[22:0] != 23'd0);
        b_nan = (eb == 8'hff) && (op_b[22:0] != 23'd0);
        a_inf = (ea == 8'hff) && (op_a[22:0] == 23'd0);
        b_inf = (eb == 8'hff) && (op_b[22:0] == 23'd0);
        mag_a = (ea == 8'd0) ? 31'd0 : op_a[30:0];
        mag_b = (eb == 8'd0) ? 31'd0 : op_b[30:0];
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
        swap  = mag_b > mag_a;
        u_spec_vld = a_nan | b_nan | a_inf | b_inf;
        u_spec_val = 32'h7fc00000;
        if (a_nan || b_nan)
            u_spec_val = 32'h7fc00000;
        else if (a_inf && b_inf)
            u_spec_val = (op_a[31] == op_b[31]) ? 32'h7fc00000 : op_a;
        else if (a_inf)
            u_spec_val = op_a;
        else if (b_inf)
            u_spec_val = {sb, 8'hff, 23'd0};
    end

    // Align: anything shifted past the R position collapses into sticky.
    logic [7:0]  diff;
    logic [53:0] wide;
    logic [26:0] y_shift;
    always_comb begin
        diff = ex - ey;
        wide = {my, 3'b000, 27'd0} >> diff;
        if (diff >= 8'd27)
            y_shift = {26'd0, |my};
        else
            y_shift = wide[53:27] | {26'd0, |wide[26:0]};
    end

    logic [4:0] lz;
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
    end

    logic [26:0] n_m;
    logic [9:0]  n_e;
    logic        n_z, n_zs;
    always_comb begin
        n_m  = sum[26:0] << lz;
        n_e  = {2'b00, ex} - {5'd0, lz};
        n_z  = 1'b0;
        n_zs = sx;
        if (sum[27]) begin
            n_m = sum[27:1] | {26'd0, sum[0]};
            n_e = {2'b00, ex} + 10'd1;
        end else if (sum[26:0] == 27'd0) begin
            // exact zero is +0 unless both operands were -0 after sign inversion
            n_z  = 1'b1;
            n_zs = sx & sy;
        end else if ({2'b00, ex} <= {5'd0, lz}) begin
            n_z = 1'b1;
        end
    end

    logic        inc;
    logic [24:0] r_sig;
    logic [9:0]  r_exp;
    always_comb begin
        inc   = nm[2] & (nm[3] | nm[1] | nm[0]);
        r_sig = {1'b0, nm[26:3]} + {24'd0, inc};
        r_exp = ne + {9'd0, r_sig[24]};
        if (spec_vld)
            res = spec_val;
        else if (nz)
            res = {nz_sign, 31'd0};
        else if (r_exp >= 10'd255)
            res = {sx, 8'hff, 23'd0};
        else
            res = {sx, r_exp[7:0], r_sig[24] ? 23'd0 : r_sig[22:0]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0; op_b <= '0;
            sx <= 1'b0; sy <= 1'b0; ex <= '0; ey <= '0; mx <= '0; my <= '0;
            spec_vld <= 1'b0; spec_val <= '0;
            xe <= '0; ye <= '0; sum <= '0;
            nm <= '0; ne <= '0; nz <= 1'b0; nz_sign <= 1'b0;
            c_hold <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_a <= a;
                    op_b <= b;
                end
                UNPACK: begin
                    sx <= swap ? sb : sa;
                    sy <= swap ? sa : sb;
                    ex <= swap ? eb : ea;
                    ey <= swap ? ea : eb;
                    mx <= swap ? mb : ma;
                    my <= swap ? ma : mb;
                    spec_vld <= u_spec_vld;
                    spec_val <= u_spec_val;
                end
                ALIGN: begin
                    xe <= {mx, 3'b000};
                    ye <= y_shift;
                end
                ADD: sum <= (sx ^ sy) ? ({1'b0, xe} - {1'b0, ye}) : ({1'b0, xe} + {1'b0, ye});
                NORM: begin
                    nm      <= n_m;
                    ne      <= n_e;
                    nz      <= n_z;
                    nz_sign <= n_zs;
                end
                ROUND: c_hold <= res;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == ROUND);
    assign c    = done ? res : c_hold;
endmodule

// File: tb/tb_fsub_single_seq.sv
// Bench for fsub_single_seq: directed spec vectors plus randomized operands against an exact big-integer model.
module tb_fsub_single_seq;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] a, b, c;
    logic        busy, done;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fsub_single_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact a - b on wide integers, then round-to-nearest-even; denormals flush to zero.
    function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        logic [279:0] ma, mb, mag, sig, rem, half, one;
        logic         sa, sb, sr;
        int           p, e;
        logic         x_nan, y_nan, x_inf, y_inf;
        x_nan = (x[30:23] == 8'hff) && (x[22:0] != 0);
        y_nan = (y[30:23] == 8'hff) && (y[22:0] != 0);
        x_inf = (x[30:23] == 8'hff) && (x[22:0] == 0);
        y_inf = (y[30:23] == 8'hff) && (y[22:0] == 0);
        if (x_nan || y_nan) return 32'h7fc00000;
        if (x_inf && y_inf) return (x[31] == y[31]) ? 32'h7fc00000 : x;
        if (x_inf) return x;
        if (y_inf) return {~y[31], 8'hff, 23'd0};
        sa = x[31];
        sb = ~y[31];
        ma = 280'({1'b1, x[22:0]});
        mb = 280'({1'b1, y[22:0]});
        ma = (x[30:23] == 0) ? 280'd0 : ma << (int'(x[30:23]) - 1);
        mb = (y[30:23] == 0) ? 280'd0 : mb << (int'(y[30:23]) - 1);
        if (ma == 0 && mb == 0) return {sa & sb, 31'd0};
        if (sa == sb)      begin mag = ma + mb; sr = sa; end
        else if (ma >= mb) begin mag = ma - mb; sr = sa; end
        else               begin mag = mb - ma; sr = sb; end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 280; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return {sr, 31'd0};
        one = 280'd1;
        if (p > 23) begin
            sig  = mag >> (p - 23);
            rem  = mag & ((one << (p - 23)) - 1);
            half = one << (p - 24);
            if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        end else begin
            sig = mag << (23 - p);
        end
        if (sig[24]) begin sig = sig >> 1; e++; end
        if (e >= 255) return {sr, 8'hff, 23'd0};
        return {sr, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] sp [8] = '{32'h0, 32'h80000000, 32'h7f800000, 32'hff800000,
                                32'h7fc00000, 32'h7f7fffff, 32'h00000001, 32'h3f800000};
        case ($urandom_range(0, 15))
            0:       return sp[$urandom_range(0, 7)];
            1:       return {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
            2:       return {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // noise: scramble inputs and pulse start while busy; sod: assert start in the done cycle
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic [31:0] exp_c,
                          input string tag, input bit noise, input bit sod);
        @(negedge clk);
        a = ta; b = tb_op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc > 1) @(negedge clk);
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done"}, 32'(done), (cyc == 5) ? 32'd1 : 32'd0);
            if (noise && cyc < 5) begin
                a = $urandom; b = $urandom; start = 1'($urandom);
            end
            if (cyc == 5) begin
                chk({tag, ".c"}, c, exp_c);
                start = sod;
                if (sod) begin a = $urandom; b = $urandom; end
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".hold_c"}, c, exp_c);
    endtask

    logic [31:0] dir [11][3] = '{
        '{32'h40900007, 32'h41f00003, 32'hc1cc0001},
        '{32'h40400000, 32'h3f800000, 32'h40000000},
        '{32'h3f800000, 32'hbf800000, 32'h40000000},
        '{32'h3fc00000, 32'h3fc00000, 32'h00000000},
        '{32'h80000000, 32'h00000000, 32'h80000000},
        '{32'h7f800000, 32'h7f800000, 32'h7fc00000},
        '{32'h7f7fffff, 32'hff7fffff, 32'h7f800000},
        '{32'h3f800000, 32'h7f800000, 32'hff800000},
        '{32'h7fc00001, 32'h3f800000, 32'h7fc00000},
        '{32'hff800000, 32'h3f800000, 32'hff800000},
        '{32'h00000001, 32'h80000001, 32'h00000000}
    };

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.c", c, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(dir[i][0], dir[i][1], dir[i][2], $sformatf("dir%0d", i), 1'b0, 1'b0);

        run_op(32'h40900007, 32'h41f00003, 32'hc1cc0001, "noise", 1'b1, 1'b0);
        run_op(32'h40400000, 32'h3f800000, 32'h40000000, "start_on_done", 1'b0, 1'b1);

        // abort mid-operation: outputs clear at once and no done follows
        @(negedge clk);
        a = 32'h3f800000; b = 32'hbf800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.c", c, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(done), 32'd0);
        end
        run_op(32'h40400000, 32'h3f800000, 32'h40000000, "after_abort", 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            ra = rnd_fp();
            case ($urandom_range(0, 3))
                0:       rb = rnd_fp();
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 25));
                2:       rb = {1'($urandom), ra[30:0] + 31'($urandom_range(0, 3))};
                default: rb = {1'($urandom), 8'(ra[30:23] - 8'($urandom_range(0, 30))), 23'($urandom)};
            endcase
            run_op(ra, rb, ref_sub(ra, rb), $sformatf("rnd%0d", n),
                   $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
